// File: rtl/flex_sr_pkg.sv
// flex_sr_pkg: shared types and helpers for the flex serial-to-parallel framer.
package flex_sr_pkg;

  // Framer FSM: STP_PARITY is only reachable when FLEX_STP_PARITY_EN is defined.
  typedef enum logic {
    STP_DATA   = 1'b0,
    STP_PARITY = 1'b1
  } stp_state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flex_stp_framer_if.sv
// flex_stp_framer_if: bit-side inputs and word-side handshake of the framer.
// master = bit source / word consumer side, slave = the framer itself.
interface flex_stp_framer_if #(
  parameter int NUM_BITS = 8
);
  logic                shift_enable;
  logic                serial_in;
  logic                clear;
  logic                data_ready;
  logic [NUM_BITS-1:0] data_out;
  logic                data_valid;
  logic                overrun_error;
  logic                parity_error;

  modport master (
    output shift_enable, serial_in, clear, data_ready,
    input  data_out, data_valid, overrun_error, parity_error
  );

  modport slave (
    input  shift_enable, serial_in, clear, data_ready,
    output data_out, data_valid, overrun_error, parity_error
  );
endinterface

// File: rtl/flex_counter.sv
// flex_counter: wrapping up-counter with synchronous clear and a registered
// rollover_flag that is high while the count sits at rollover_val.
module flex_counter
  import flex_sr_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic             rollover_flag
);
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  // Next count: clear wins, otherwise step and wrap at rollover_val.
  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (count_enable) begin
      if (count_q == rollover_val) count_d = '0;
      else                         count_d = count_q + 1'b1;
      flag_d = (count_d == rollover_val);
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign rollover_flag = flag_q;
endmodule

// File: rtl/flex_stp_framer.sv
// flex_stp_framer: serial-to-parallel deserializer with word framing,
// valid/ready holding register, sticky overrun and optional even parity.
// Optional feature macro: FLEX_STP_PARITY_EN (adds a parity bit per word).
module flex_stp_framer
  import flex_sr_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  flex_stp_framer_if.slave  bus
);
  localparam int                  CNT_W    = cnt_width(NUM_BITS);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(NUM_BITS - 1);
  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

  stp_state_t          state_q, state_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [NUM_BITS-1:0] data_out_q, data_out_d;
  logic [NUM_BITS-1:0] shifted;
  logic                data_valid_q, data_valid_d;
  logic                overrun_q, overrun_d;
  logic                rollover_flag;
  logic                count_en;
  logic                word_done;
`ifdef FLEX_STP_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // Bits are only counted while collecting data, never for the parity bit.
  assign count_en = bus.shift_enable & (state_q == STP_DATA);

  flex_counter #(.CNT_W(CNT_W)) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bus.clear),
    .count_enable (count_en),
    .rollover_val (LAST_BIT),
    .rollover_flag(rollover_flag)
  );

  // Shift direction is fixed at elaboration.
  generate
    if (SHIFT_MSB != 0) begin : g_shift_msb
      assign shifted = {sr_q[NUM_BITS-2:0], bus.serial_in};
    end else begin : g_shift_lsb
      assign shifted = {bus.serial_in, sr_q[NUM_BITS-1:1]};
    end
  endgenerate

  // Next-state: shifting, word publication, handshake and error flags.
  always_comb begin
    word_done    = 1'b0;
    state_d      = state_q;
    sr_d         = sr_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
`ifdef FLEX_STP_PARITY_EN
    parity_d     = parity_q;
`endif
    if (bus.clear) begin
      state_d      = STP_DATA;
      sr_d         = ALL_ONES;
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
`ifdef FLEX_STP_PARITY_EN
      parity_d     = 1'b0;
`endif
    end else begin
      if (bus.shift_enable) begin
        if (state_q == STP_DATA) begin
          sr_d = shifted;
          if (rollover_flag) begin
`ifdef FLEX_STP_PARITY_EN
            state_d = STP_PARITY;
`else
            word_done  = 1'b1;
            data_out_d = shifted;
`endif
          end
        end
`ifdef FLEX_STP_PARITY_EN
        else begin
          // Parity bit: publish the word already held, do not shift.
          word_done  = 1'b1;
          data_out_d = sr_q;
          parity_d   = (^sr_q) ^ bus.serial_in;
          state_d    = STP_DATA;
        end
`endif
      end
      // A new word keeps valid high even if the old one is accepted now.
      if (word_done) begin
        data_valid_d = 1'b1;
        if (data_valid_q & ~bus.data_ready) overrun_d = 1'b1;
      end else if (data_valid_q & bus.data_ready) begin
        data_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= STP_DATA;
      sr_q         <= ALL_ONES;
      data_out_q   <= ALL_ONES;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FLEX_STP_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
`ifdef FLEX_STP_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.overrun_error = overrun_q;
`ifdef FLEX_STP_PARITY_EN
  assign bus.parity_error  = parity_q;
`else
  assign bus.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_flex_stp_framer.sv
// tb_flex_stp_framer: drives an MSB-first and an LSB-first framer with the
// same stimulus; checks a vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_flex_stp_framer;
  localparam int N = 8;
`ifdef FLEX_STP_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  flex_stp_framer_if #(.NUM_BITS(N)) bus_m ();
  flex_stp_framer_if #(.NUM_BITS(N)) bus_l ();

  flex_stp_framer #(.NUM_BITS(N), .SHIFT_MSB(1)) dut_m (.clk(clk), .n_rst(n_rst), .bus(bus_m));
  flex_stp_framer #(.NUM_BITS(N), .SHIFT_MSB(0)) dut_l (.clk(clk), .n_rst(n_rst), .bus(bus_l));

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the current word in arrival order.
  bit           mq[$];
  bit           m_valid, m_ovr, m_par;
  bit [N-1:0]   m_dm, m_dl;
  int           words = 0;

  typedef struct {
    bit         se, si, clr, rdy;
    bit         ev;
    bit [N-1:0] edm, edl;
    bit         eovr, epar;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
    m_dm = '1; m_dl = '1;
  endtask

  // Publish the collected bits as a word for both shift directions.
  task automatic model_publish(input bit rdy);
    bit [N-1:0] wm, wl;
    wm = '0; wl = '0;
    for (int i = 0; i < N; i++) begin
      wm = (wm << 1) | N'(mq[i]);
      wl = wl | (N'(mq[i]) << i);
    end
    if (m_valid && !rdy) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_dm = wm; m_dl = wl;
    mq.delete();
    words++;
    $display("word %0d: msb_first=%02h lsb_first=%02h ovr=%0d par=%0d", words, wm, wl, m_ovr, m_par);
  endtask

  task automatic model_step(input bit se, input bit si, input bit clr, input bit rdy);
    int ones;
    bit done;
    done = 1'b0;
    if (clr) begin
      mq.delete();
      m_valid = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
      return;
    end
    if (se) begin
      if (PAR && mq.size() == N) begin
        ones = 0;
        foreach (mq[i]) ones += int'(mq[i]);
        m_par = ((ones % 2) != 0) ^ si;
        done = 1'b1;
      end else begin
        mq.push_back(si);
        if (!PAR && mq.size() == N) done = 1'b1;
      end
    end
    if (done) model_publish(rdy);
    else if (m_valid && rdy) m_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".m.valid"}, 32'(bus_m.data_valid),    32'(m_valid));
    chk({tag, ".m.dout"},  32'(bus_m.data_out),      32'(m_dm));
    chk({tag, ".m.ovr"},   32'(bus_m.overrun_error), 32'(m_ovr));
    chk({tag, ".m.par"},   32'(bus_m.parity_error),  32'(m_par));
    chk({tag, ".l.valid"}, 32'(bus_l.data_valid),    32'(m_valid));
    chk({tag, ".l.dout"},  32'(bus_l.data_out),      32'(m_dl));
    chk({tag, ".l.ovr"},   32'(bus_l.overrun_error), 32'(m_ovr));
    chk({tag, ".l.par"},   32'(bus_l.parity_error),  32'(m_par));
  endtask

  // One clock: drive after the falling edge, check at the next falling edge.
  task automatic cycle(input bit se, input bit si, input bit clr, input bit rdy, input string tag);
    bus_m.shift_enable = se; bus_m.serial_in = si; bus_m.clear = clr; bus_m.data_ready = rdy;
    bus_l.shift_enable = se; bus_l.serial_in = si; bus_l.clear = clr; bus_l.data_ready = rdy;
    @(posedge clk);
    model_step(se, si, clr, rdy);
    @(negedge clk);
    check_model(tag);
  endtask

  // Send one word MSB-first in time; ready is raised only on the completing edge.
  task automatic send_word(input bit [N-1:0] pat, input bit rdy_last, input bit pbit, input string tag);
    for (int i = 0; i < N; i++)
      cycle(1'b1, pat[N-1-i], 1'b0, (i == N-1 && !PAR) ? rdy_last : 1'b0, tag);
    if (PAR) cycle(1'b1, pbit, 1'b0, rdy_last, tag);
  endtask

  function automatic void push_row(input bit se, input bit si, input bit rdy, input bit ev,
                                   input bit [N-1:0] edm, input bit [N-1:0] edl, input bit epar);
    vec_t v;
    v.se = se; v.si = si; v.clr = 1'b0; v.rdy = rdy; v.ev = ev;
    v.edm = edm; v.edl = edl; v.eovr = 1'b0; v.epar = epar;
    tbl.push_back(v);
  endfunction

  // Table rows for one word held with ready low, followed by one accept cycle.
  function automatic void push_word(input bit [N-1:0] pat, input bit pbit,
                                    input bit [N-1:0] pdm, input bit [N-1:0] pdl, input bit ppar,
                                    input bit [N-1:0] edm, input bit [N-1:0] edl, input bit epar);
    bit last;
    for (int i = 0; i < N; i++) begin
      last = (i == N-1) && !PAR;
      push_row(1'b1, pat[N-1-i], 1'b0, last, last ? edm : pdm, last ? edl : pdl, last ? epar : ppar);
    end
    if (PAR) push_row(1'b1, pbit, 1'b0, 1'b1, edm, edl, epar);
    push_row(1'b0, 1'b0, 1'b1, 1'b0, edm, edl, epar);
  endfunction

  initial begin
    int w0;
    bit [N-1:0] pat;
    model_reset();
    bus_m.shift_enable = 0; bus_m.serial_in = 0; bus_m.clear = 0; bus_m.data_ready = 0;
    bus_l.shift_enable = 0; bus_l.serial_in = 0; bus_l.clear = 0; bus_l.data_ready = 0;

    // Reset values while n_rst is held low.
    @(negedge clk); @(negedge clk);
    chk("rst.m.dout",  32'(bus_m.data_out),   32'hFF);
    chk("rst.m.valid", 32'(bus_m.data_valid), 32'h0);
    chk("rst.l.dout",  32'(bus_l.data_out),   32'hFF);
    chk("rst.l.ovr",   32'(bus_l.overrun_error), 32'h0);
    n_rst = 1'b1;

    // Table: A5 (palindrome), C0 (03 reversed), then A5 with a bad parity bit.
    push_word(8'hA5, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hA5, 8'hA5, 1'b0);
    push_word(8'hC0, 1'b0, 8'hA5, 8'hA5, 1'b0, 8'hC0, 8'h03, 1'b0);
    if (PAR) push_word(8'hA5, 1'b1, 8'hC0, 8'h03, 1'b0, 8'hA5, 8'hA5, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].se, tbl[i].si, tbl[i].clr, tbl[i].rdy, "tbl");
      chk($sformatf("tbl%0d.valid", i), 32'(bus_m.data_valid),    32'(tbl[i].ev));
      chk($sformatf("tbl%0d.m",     i), 32'(bus_m.data_out),      32'(tbl[i].edm));
      chk($sformatf("tbl%0d.l",     i), 32'(bus_l.data_out),      32'(tbl[i].edl));
      chk($sformatf("tbl%0d.ovr",   i), 32'(bus_m.overrun_error), 32'(tbl[i].eovr));
      chk($sformatf("tbl%0d.par",   i), 32'(bus_m.parity_error),  32'(tbl[i].epar));
    end

    // Gapped enable: 8 enabled cycles out of 16 make exactly one data word.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "gap.clr");
    w0 = words;
    for (int k = 0; k < 16; k++) cycle(k[0], 1'($urandom), 1'b0, 1'b0, "gap");
    chk("gap.words", 32'(words - w0), PAR ? 32'd0 : 32'd1);
    chk("gap.valid", 32'(bus_m.data_valid), PAR ? 32'd0 : 32'd1);

    // Overrun: two words with ready low.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "ovr.clr");
    send_word(8'h5A, 1'b0, 1'b0, "ovr");
    send_word(8'h96, 1'b0, 1'b0, "ovr");
    chk("ovr.dout", 32'(bus_m.data_out),      32'h96);
    chk("ovr.flag", 32'(bus_m.overrun_error), 32'h1);

    // Accept on the completion edge is not an overrun.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "acc.clr");
    send_word(8'h5A, 1'b0, 1'b0, "acc");
    send_word(8'h69, 1'b1, 1'b0, "acc");
    chk("acc.valid", 32'(bus_m.data_valid),    32'h1);
    chk("acc.flag",  32'(bus_m.overrun_error), 32'h0);
    chk("acc.dout",  32'(bus_m.data_out),      32'h69);

    // Clear mid-word: 5 stray bits, clear, then a full 3C word.
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0, "clr.pre");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "clr");
    send_word(8'h3C, 1'b0, 1'b0, "clr");
    chk("clr.m", 32'(bus_m.data_out), 32'h3C);
    chk("clr.l", 32'(bus_l.data_out), 32'h3C);
    chk("clr.errs", 32'({bus_m.overrun_error, bus_m.parity_error}), 32'h0);

    // Asynchronous reset mid-word, asserted away from any clock edge.
    send_word(8'h81, 1'b0, 1'b0, "arst");
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "arst");
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("arst.valid", 32'(bus_m.data_valid), 32'h0);
    chk("arst.dout",  32'(bus_m.data_out),   32'hFF);
    @(negedge clk);
    n_rst = 1'b1;

    // Randomized traffic against the reference model.
    for (int k = 0; k < 1500; k++) begin
      pat = N'($urandom);
      cycle($urandom_range(0, 9) < 7, pat[0], $urandom_range(0, 49) == 0,
            $urandom_range(0, 1) == 1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
